arb_rr_bin: RTL and testbench



---
 rtl/arb_pkg.sv | 13 +
 rtl/enc_rr_bin.sv | 58 +++++
 rtl/arb_rr_bin.sv | 114 +++++++++++
 tb/tb_arb_rr_bin.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// -----------------------------------------------------------------------------
// arb_pkg
// Shared definitions for the round-robin binary-grant arbiter.
//   arb_state_t : handshake FSM state (IDLE = no grant, GRANT = bin/vld valid)
// -----------------------------------------------------------------------------
package arb_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

endpackage

// File: rtl/enc_rr_bin.sv
// -----------------------------------------------------------------------------
// enc_rr_bin
// Combinational round-robin encoder. Finds the first asserted request bit
// searching upward from ptr with wrap-around at WIDTH.
//   req : request vector (WIDTH)
//   ptr : search origin, always < WIDTH (WIDTH_LOG)
//   idx : binary index of the selected requester (WIDTH_LOG)
//   any : at least one request bit is set
// -----------------------------------------------------------------------------
module enc_rr_bin #(
  parameter  int WIDTH     = 32,
  localparam int WIDTH_LOG = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0]     req,
  input  logic [WIDTH_LOG-1:0] ptr,
  output logic [WIDTH_LOG-1:0] idx,
  output logic                 any
);

  localparam logic [WIDTH_LOG:0] WIDTH_EXT = (WIDTH_LOG+1)'(WIDTH);

  // (base + off) mod WIDTH; base < WIDTH and off <= WIDTH, so one subtract suffices.
  // One extra bit keeps the sum exact even for non-power-of-2 WIDTH.
  function automatic logic [WIDTH_LOG-1:0] wrap_add(input logic [WIDTH_LOG-1:0] base,
                                                     input logic [WIDTH_LOG:0]   off);
    logic [WIDTH_LOG:0] sum;
    sum = {1'b0, base} + off;
    if (sum >= WIDTH_EXT) begin
      sum = sum - WIDTH_EXT;
    end else begin
      sum = sum;
    end
    return sum[WIDTH_LOG-1:0];
  endfunction

  logic [WIDTH-1:0]   rot_s;
  logic [WIDTH_LOG:0] off_s;

  // Rotate so that bit 0 of rot_s corresponds to requester ptr.
  always_comb begin
    rot_s = '0;
    for (int j = 0; j < WIDTH; j++) begin
      rot_s[j] = req[wrap_add(ptr, (WIDTH_LOG+1)'(j))];
    end
  end

  // Fixed-priority encode of the rotated vector; the downward scan leaves the lowest set bit.
  always_comb begin
    off_s = '0;
    for (int j = WIDTH - 1; j >= 0; j--) begin
      off_s = rot_s[j] ? (WIDTH_LOG+1)'(j) : off_s;
    end
  end

  assign idx = wrap_add(ptr, off_s);
  assign any = |req;

endmodule

// File: rtl/arb_rr_bin.sv
// -----------------------------------------------------------------------------
// arb_rr_bin
// Round-robin arbiter with a registered binary grant and valid/ready handshake.
// The grant index drives a downstream mux select and is held for the whole
// handshake.
//   clk : clock, rising edge
//   rst : asynchronous active-high reset
//   req : per-requester request, held until the matching ack bit (WIDTH)
//   bin : registered binary index of the granted requester (WIDTH_LOG)
//   vld : registered grant-valid
//   rdy : downstream accepts the selected data
//   ack : one-hot transfer acknowledge, vld & rdy & (bin == i) (WIDTH)
// -----------------------------------------------------------------------------
module arb_rr_bin
  import arb_pkg::*;
#(
  parameter  int WIDTH     = 32,
  localparam int WIDTH_LOG = $clog2(WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     req,
  output logic [WIDTH_LOG-1:0] bin,
  output logic                 vld,
  input  logic                 rdy,
  output logic [WIDTH-1:0]     ack
);

  arb_state_t           state_q, state_d;
  logic [WIDTH_LOG-1:0] bin_q, bin_d;
  logic [WIDTH_LOG-1:0] ptr_q, ptr_d;
  logic                 xfer_s;
  logic [WIDTH-1:0]     req_m_s;
  logic [WIDTH_LOG-1:0] sel_s;
  logic                 sel_any_s;

  assign vld    = (state_q == GRANT);
  assign bin    = bin_q;
  assign xfer_s = vld & rdy;

  // One-hot acknowledge of the current grant while the transfer happens.
  always_comb begin
    ack = '0;
    for (int i = 0; i < WIDTH; i++) begin
      ack[i] = xfer_s & (bin_q == WIDTH_LOG'(i));
    end
  end

  // The acknowledged requester still holds req this cycle; hide it from the next selection.
  assign req_m_s = req & ~ack;

  // Pointer moves just past the winner on a transfer; wrap at WIDTH, not 2^WIDTH_LOG.
  always_comb begin
    if (xfer_s) begin
      ptr_d = (bin_q == WIDTH_LOG'(WIDTH - 1)) ? '0 : bin_q + WIDTH_LOG'(1);
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Selection uses the updated pointer so back-to-back grants already rotate.
  enc_rr_bin #(
    .WIDTH (WIDTH)
  ) u_enc (
    .req (req_m_s),
    .ptr (ptr_d),
    .idx (sel_s),
    .any (sel_any_s)
  );

  // Handshake FSM: bin is loaded only on a new grant and frozen otherwise.
  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    case (state_q)
      IDLE: begin
        if (sel_any_s) begin
          state_d = GRANT;
          bin_d   = sel_s;
        end else begin
          state_d = IDLE;
        end
      end
      GRANT: begin
        if (xfer_s) begin
          if (sel_any_s) begin
            bin_d = sel_s;
          end else begin
            state_d = IDLE;
          end
        end else begin
          state_d = GRANT;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, grant index and pointer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      bin_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      ptr_q   <= ptr_d;
    end
  end

endmodule

// File: tb/tb_arb_rr_bin.sv
// -----------------------------------------------------------------------------
// tb_arb_rr_bin
// Self-checking bench for arb_rr_bin: an 8-requester instance tracked by a
// behavioural round-robin model, and a 5-requester instance for the
// non-power-of-2 wrap.
// -----------------------------------------------------------------------------
module tb_arb_rr_bin;

  localparam int W8 = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req8 = 8'h00;
  logic       rdy8 = 1'b0;
  logic [2:0] bin8;
  logic       vld8;
  logic [7:0] ack8;
  logic [4:0] req5 = 5'h00;
  logic       rdy5 = 1'b0;
  logic [2:0] bin5;
  logic       vld5;
  logic [4:0] ack5;

  int checks   = 0;
  int failures = 0;

  // behavioural model of the 8-requester instance
  bit         m_vld;
  int         m_bin;
  int         m_ptr;
  logic [7:0] last_ack;
  int         wait_c [W8];

  arb_rr_bin #(.WIDTH(8)) u8 (
    .clk (clk), .rst (rst), .req (req8), .bin (bin8),
    .vld (vld8), .rdy (rdy8), .ack (ack8)
  );

  arb_rr_bin #(.WIDTH(5)) u5 (
    .clk (clk), .rst (rst), .req (req5), .bin (bin5),
    .vld (vld5), .rdy (rdy5), .ack (ack5)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // first requester at or after p (cyclically) with its bit set in r
  function automatic int pick(input logic [7:0] r, input int p);
    for (int k = 0; k < W8; k++) begin
      if (r[(p + k) % W8]) return (p + k) % W8;
    end
    return 0;
  endfunction

  task automatic model_reset();
    m_vld    = 1'b0;
    m_bin    = 0;
    m_ptr    = 0;
    last_ack = 8'h00;
    for (int i = 0; i < W8; i++) wait_c[i] = 0;
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    req8 = 8'h00; rdy8 = 1'b0;
    req5 = 5'h00; rdy5 = 1'b0;
    @(posedge clk); @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
  endtask

  // one clock of the 8-requester instance: check ack, advance, update model, check grant
  task automatic cyc();
    logic [7:0] ea;
    logic [7:0] r;
    bit         hold;
    int         saved;
    #1;
    ea = (m_vld && rdy8) ? (8'h01 << m_bin) : 8'h00;
    chk("ack8", {56'd0, ack8}, {56'd0, ea});
    hold  = m_vld && !rdy8;
    saved = m_bin;
    @(posedge clk);
    if (m_vld) begin
      if (rdy8) begin
        m_ptr = (m_bin + 1) % W8;
        r = req8 & ~ea;
        if (r != 8'h00) m_bin = pick(r, m_ptr);
        else            m_vld = 1'b0;
      end
    end else if (req8 != 8'h00) begin
      m_bin = pick(req8, m_ptr);
      m_vld = 1'b1;
    end
    #1;
    chk("vld8", {63'd0, vld8}, {63'd0, m_vld});
    chk("bin8", {61'd0, bin8}, 64'(m_bin));
    if (hold) chk("hold_bin", {61'd0, bin8}, 64'(saved));
    last_ack = ea;
  endtask

  initial begin
    logic [7:0] req_edge;
    bit         over;

    // reset state
    do_reset();
    chk("rst_vld", {63'd0, vld8}, 64'd0);
    chk("rst_bin", {61'd0, bin8}, 64'd0);
    chk("rst_ack", {56'd0, ack8}, 64'd0);

    // single request: grant one cycle later, ack in that cycle, then idle
    req8 = 8'h10; rdy8 = 1'b1;
    cyc();
    chk("single_vld", {63'd0, vld8}, 64'd1);
    chk("single_bin", {61'd0, bin8}, 64'd4);
    chk("single_ack", {56'd0, ack8}, 64'h10);
    cyc();
    req8 = req8 & ~last_ack;
    chk("single_idle", {63'd0, vld8}, 64'd0);

    // rotation: all requesting, rdy held -> 0..7,0 with no bubbles
    do_reset();
    req8 = 8'hFF; rdy8 = 1'b1;
    for (int i = 0; i < 9; i++) begin
      cyc();
      chk("rot_vld", {63'd0, vld8}, 64'd1);
      chk("rot_bin", {61'd0, bin8}, 64'(i % 8));
    end

    // backpressure: grant frozen while rdy low
    do_reset();
    req8 = 8'h06; rdy8 = 1'b0;
    cyc();
    chk("bp_first", {61'd0, bin8}, 64'd1);
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("bp_bin", {61'd0, bin8}, 64'd1);
      chk("bp_ack", {56'd0, ack8}, 64'd0);
    end
    rdy8 = 1'b1;
    #1 chk("bp_ack_rdy", {56'd0, ack8}, 64'h02);
    cyc();
    req8 = req8 & ~last_ack;
    chk("bp_next_bin", {61'd0, bin8}, 64'd2);
    chk("bp_next_vld", {63'd0, vld8}, 64'd1);
    cyc();
    req8 = req8 & ~last_ack;
    cyc();
    chk("bp_idle", {63'd0, vld8}, 64'd0);

    // reset mid-grant drops everything without a clock edge
    do_reset();
    req8 = 8'h20; rdy8 = 1'b0;
    cyc();
    chk("mid_bin5", {61'd0, bin8}, 64'd5);
    rdy8 = 1'b1;
    #1 rst = 1'b1;
    #1;
    chk("mid_vld", {63'd0, vld8}, 64'd0);
    chk("mid_bin", {61'd0, bin8}, 64'd0);
    chk("mid_ack", {56'd0, ack8}, 64'd0);
    model_reset();
    req8 = 8'h01;
    rst  = 1'b0;
    cyc();
    chk("post_rst_bin", {61'd0, bin8}, 64'd0);
    chk("post_rst_vld", {63'd0, vld8}, 64'd1);
    cyc();
    req8 = req8 & ~last_ack;

    // random load: protocol-following requesters, random rdy, model + fairness
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      req8 = req8 | (8'($urandom) & 8'($urandom));
      rdy8 = ($urandom_range(0, 3) != 0);
      req_edge = req8;
      cyc();
      req8 = req8 & ~last_ack;
      if (last_ack != 8'h00) begin
        over = 1'b0;
        for (int i = 0; i < W8; i++) begin
          if (last_ack[i]) begin
            wait_c[i] = 0;
          end else if (req_edge[i]) begin
            wait_c[i] = wait_c[i] + 1;
            if (wait_c[i] > W8 - 1) over = 1'b1;
          end
        end
        chk("fair_wait", {63'd0, over}, 64'd0);
      end
    end

    // non-power-of-2 width: bits 0 and 4 alternate, pointer stays below 5
    do_reset();
    req5 = 5'h11; rdy5 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      chk("w5_vld", {63'd0, vld5}, 64'd1);
      chk("w5_bin", {61'd0, bin5}, (i % 2 == 1) ? 64'd4 : 64'd0);
      chk("w5_ptr", {63'd0, (u5.ptr_q < 3'd5)}, 64'd1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
